io_port_arbiter: RTL

- Shares the computer's 16-entry, 8-bit I/O port bank between NREQ bus masters (CPU core, loader/DMA, debug).
- Owns the output-port registers that drive port_out_data, and samples port_in_data on reads.
- Grants one transaction at a time with round-robin fairness and a programmable wait-state count.
- Flags simulation/run termination when bit 0 of output port 15 is set.

---
 rtl/io_port_arbiter_if.sv | 25 ++
 rtl/io_port_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/io_port_arbiter_if.sv
// Requester-side bus of the I/O port arbiter: per-requester request/command
// lanes plus the shared grant, ack and read-data returns.
interface io_port_arbiter_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/io_port_arbiter.sv
// Round-robin arbiter that shares the I/O port bank between NREQ masters,
// owns the output-port registers and raises halt from port 15 bit 0.
module io_port_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NPORT    = 16,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  io_port_arbiter_if.slave        bus,
  input  logic [NPORT*DATA_W-1:0] port_in_data,
  output logic [NPORT*DATA_W-1:0] port_out_data,
  output logic                    halt
);

  localparam int unsigned ADDR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    own_q, own_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [DATA_W-1:0]   port_q [NPORT];
  logic [DATA_W-1:0]   port_d [NPORT];

  logic                found_c;
  logic [IDX_W-1:0]    sel_c;
  int unsigned         rr_idx;

  // First requesting master at or after the round-robin pointer, with wrap.
  always_comb begin
    found_c = 1'b0;
    sel_c   = rr_q;
    rr_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = 32'(rr_q) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!found_c && bus.req[IDX_W'(rr_idx)]) begin
        found_c = 1'b1;
        sel_c   = IDX_W'(rr_idx);
      end
    end
  end

  // Next-state and register-update logic for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    port_d  = port_q;

    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          own_d   = sel_c;
          we_d    = bus.we[sel_c];
          addr_d  = bus.addr[32'(sel_c)*ADDR_W +: ADDR_W];
          wdata_d = bus.wdata[32'(sel_c)*DATA_W +: DATA_W];
          cnt_d   = CNT_W'(WAIT_CYC);
          gnt_d   = NREQ'(1) << sel_c;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (we_q) port_d[addr_q] = wdata_q;
          else      rdata_d = port_in_data[32'(addr_q)*DATA_W +: DATA_W];
          ack_d   = NREQ'(1) << own_q;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        rr_d    = (32'(own_q) == NREQ - 1) ? IDX_W'(0) : own_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      for (int unsigned p = 0; p < NPORT; p++) port_q[p] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      for (int unsigned p = 0; p < NPORT; p++) port_q[p] <= port_d[p];
    end
  end

  // Flatten the output-port registers onto the port bus.
  always_comb begin
    port_out_data = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      port_out_data[p*DATA_W +: DATA_W] = port_q[p];
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign halt      = port_q[NPORT-1][0];

endmodule
